traffic_queue_counter: RTL and testbench



---
 rtl/traffic_queue_counter.sv | 138 +++++++++++++
 tb/tb_traffic_queue_counter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_queue_counter.sv
// Per-road vehicle queue estimator for the three-road traffic light controller.
// Counts loop-detector arrivals on roads 1-3, retires one queued vehicle every
// DEPART_CYCLES cycles of continuous green, and raises a hysteretic congestion
// request (emerg) back to the controller.
//
// Optional build macro: TRAFFIC_SYNC_EN
//   Defined   - sensor passes through a 2-flop synchronizer before the edge
//               detector (arrival-to-count latency +2 cycles).
//   Undefined - sensor is assumed synchronous to clk.
module traffic_queue_counter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEPART_CYCLES = 4,
  parameter int unsigned EMERG_ON      = 1000,
  parameter int unsigned EMERG_OFF     = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sensor,
  input  logic [2:0]       green,
  output logic [WIDTH-1:0] traffic1,
  output logic [WIDTH-1:0] traffic2,
  output logic [WIDTH-1:0] traffic3,
  output logic             emerg,
  output logic [2:0]       sat
);

  localparam int unsigned TimerW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(DEPART_CYCLES - 1);
  localparam logic [WIDTH-1:0]  CntMax    = '1;
  // Thresholds may exceed the counter range, so compare in a wide domain.
  localparam int unsigned CmpW = (WIDTH > 32) ? WIDTH : 32;
  localparam logic [CmpW-1:0] OnThr  = CmpW'(EMERG_ON);
  localparam logic [CmpW-1:0] OffThr = CmpW'(EMERG_OFF);

  logic [2:0]             sensor_s;   // sensor as seen by the edge detector
  logic [2:0]             sensor_q;
  logic [2:0]             arr;
  logic [2:0]             dep;
  logic [2:0][WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0][TimerW-1:0] tmr_q, tmr_d;
  logic [2:0]             sat_q, sat_d;
  logic                   emerg_q, emerg_d;
  logic                   any_hi, all_lo;

`ifdef TRAFFIC_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  // Two-flop synchronizer; reset preloads raw sensor so a held level is not an arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= sensor;
      sync2_q <= sensor;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
    end
  end

  assign sensor_s = sync2_q;
`else
  assign sensor_s = sensor;
`endif

  // Rising edge of the (possibly synchronized) sensor is one arrival.
  assign arr = sensor_s & ~sensor_q;

  // Per-road departure timer and queue count next-state.
  always_comb begin
    dep   = '0;
    tmr_d = '0;
    cnt_d = cnt_q;
    sat_d = sat_q;
    for (int i = 0; i < 3; i++) begin
      // Timer only runs while green with a non-empty queue; otherwise it clears.
      if (green[i] && (cnt_q[i] != '0)) begin
        if (tmr_q[i] == TimerLast) begin
          dep[i] = 1'b1;
        end else begin
          tmr_d[i] = tmr_q[i] + 1'b1;
        end
      end
      if (arr[i] && !dep[i]) begin
        if (cnt_q[i] == CntMax) begin
          sat_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!arr[i] && dep[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Hysteresis thresholds evaluated on registered counts.
  always_comb begin
    any_hi = 1'b0;
    all_lo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (CmpW'(cnt_q[i]) >= OnThr) begin
        any_hi = 1'b1;
      end
      if (CmpW'(cnt_q[i]) >= OffThr) begin
        all_lo = 1'b0;
      end
    end
    if (any_hi) begin
      emerg_d = 1'b1;
    end else if (all_lo) begin
      emerg_d = 1'b0;
    end else begin
      emerg_d = emerg_q;
    end
  end

  // State registers; sensor_q takes the raw sensor in reset to suppress a false arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      sensor_q <= sensor;
      cnt_q    <= '0;
      tmr_q    <= '0;
      sat_q    <= '0;
      emerg_q  <= 1'b0;
    end else begin
      sensor_q <= sensor_s;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      sat_q    <= sat_d;
      emerg_q  <= emerg_d;
    end
  end

  assign traffic1 = cnt_q[0];
  assign traffic2 = cnt_q[1];
  assign traffic3 = cnt_q[2];
  assign emerg    = emerg_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_traffic_queue_counter.sv
// Bench for traffic_queue_counter: a cycle model feeds a scoreboard queue for the
// main instance (thresholds 10/8), a second WIDTH=4 instance covers saturation.
module tb_traffic_queue_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sensor;
  logic [2:0]  green;
  logic [15:0] traffic1, traffic2, traffic3;
  logic        emerg;
  logic [2:0]  sat;

  logic        rst_b;
  logic [2:0]  sensor_b;
  logic [2:0]  green_b;
  logic [3:0]  traffic1_b, traffic2_b, traffic3_b;
  logic        emerg_b;
  logic [2:0]  sat_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] t1;
    logic [15:0] t2;
    logic [15:0] t3;
    logic        em;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];

  // Reference state for the main instance
  int         m_cnt[3];
  int         m_tmr[3];
  logic [2:0] m_sq;
  logic [2:0] m_sat;
  logic       m_em;
  int         tick_no = 0;

  always #5 clk = ~clk;

  traffic_queue_counter #(
    .WIDTH(16), .DEPART_CYCLES(4), .EMERG_ON(10), .EMERG_OFF(8)
  ) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .green(green),
    .traffic1(traffic1), .traffic2(traffic2), .traffic3(traffic3),
    .emerg(emerg), .sat(sat)
  );

  traffic_queue_counter #(
    .WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst(rst_b), .sensor(sensor_b), .green(green_b),
    .traffic1(traffic1_b), .traffic2(traffic2_b), .traffic3(traffic3_b),
    .emerg(emerg_b), .sat(sat_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // One clock of stimulus on the main instance; model predicts, scoreboard checks.
  task automatic tick(input logic r, input logic [2:0] s, input logic [2:0] g);
    exp_t e;
    logic hi, lo, a, d;
    @(negedge clk);
    rst = r; sensor = s; green = g;
    if (r) begin
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_tmr[i] = 0; end
      m_sat = '0; m_em = 1'b0; m_sq = s;
    end else begin
      hi = 1'b0; lo = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] >= 10) hi = 1'b1;
        if (m_cnt[i] >= 8) lo = 1'b0;
      end
      if (hi) m_em = 1'b1;
      else if (lo) m_em = 1'b0;
      for (int i = 0; i < 3; i++) begin
        a = s[i] & ~m_sq[i];
        d = 1'b0;
        if (g[i] && m_cnt[i] > 0) begin
          if (m_tmr[i] == 3) begin d = 1'b1; m_tmr[i] = 0; end
          else m_tmr[i] = m_tmr[i] + 1;
        end else begin
          m_tmr[i] = 0;
        end
        if (a && !d) begin
          if (m_cnt[i] == 65535) m_sat[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end else if (!a && d) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
      m_sq = s;
    end
    e.t1 = 16'(m_cnt[0]); e.t2 = 16'(m_cnt[1]); e.t3 = 16'(m_cnt[2]);
    e.em = m_em; e.st = m_sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick_no++;
    e = sb.pop_front();
    total++;
    if (traffic1 !== e.t1) begin
      bad++; $display("FAIL sb_traffic1 tick=%0d got=%0d want=%0d", tick_no, traffic1, e.t1);
    end
    total++;
    if (traffic2 !== e.t2) begin
      bad++; $display("FAIL sb_traffic2 tick=%0d got=%0d want=%0d", tick_no, traffic2, e.t2);
    end
    total++;
    if (traffic3 !== e.t3) begin
      bad++; $display("FAIL sb_traffic3 tick=%0d got=%0d want=%0d", tick_no, traffic3, e.t3);
    end
    total++;
    if (emerg !== e.em) begin
      bad++; $display("FAIL sb_emerg tick=%0d got=%0b want=%0b", tick_no, emerg, e.em);
    end
    total++;
    if (sat !== e.st) begin
      bad++; $display("FAIL sb_sat tick=%0d got=%b want=%b", tick_no, sat, e.st);
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 3'b111, 3'b000);
    tick(1'b1, 3'b111, 3'b000);
    for (int i = 0; i < 10; i++) tick(1'b0, 3'b111, 3'b000);
    total++;
    if ({traffic1, traffic2, traffic3} !== 48'd0) begin
      bad++; $display("FAIL reset_held_sensor got=%0d/%0d/%0d want=0/0/0",
                      traffic1, traffic2, traffic3);
    end
    total++;
    if (sat !== 3'b000) begin
      bad++; $display("FAIL reset_sat got=%b want=000", sat);
    end
  endtask

  task automatic test_arrivals();
    tick(1'b0, 3'b000, 3'b000);
    for (int p = 0; p < 5; p++) begin
      tick(1'b0, 3'b001, 3'b000);
      tick(1'b0, 3'b000, 3'b000);
      tick(1'b0, 3'b000, 3'b000);
    end
    total++;
    if (traffic1 !== 16'd5) begin
      bad++; $display("FAIL arrivals_road1 got=%0d want=5", traffic1);
    end
    total++;
    if ({traffic2, traffic3} !== 32'd0) begin
      bad++; $display("FAIL arrivals_others got=%0d/%0d want=0/0", traffic2, traffic3);
    end
  endtask

  task automatic test_departure();
    for (int c = 0; c < 12; c++) tick(1'b0, 3'b000, 3'b001);
    total++;
    if (traffic1 !== 16'd2) begin
      bad++; $display("FAIL depart_12_cycles got=%0d want=2", traffic1);
    end
    for (int c = 0; c < 3; c++) tick(1'b0, 3'b000, 3'b001);
    tick(1'b0, 3'b000, 3'b000);
    for (int c = 0; c < 3; c++) tick(1'b0, 3'b000, 3'b001);
    total++;
    if (traffic1 !== 16'd2) begin
      bad++; $display("FAIL depart_timer_restart got=%0d want=2", traffic1);
    end
    tick(1'b0, 3'b000, 3'b001);
    total++;
    if (traffic1 !== 16'd1) begin
      bad++; $display("FAIL depart_after_reassert got=%0d want=1", traffic1);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      tick(1'b0, 3'b010, 3'b000);
      tick(1'b0, 3'b000, 3'b000);
    end
    for (int c = 0; c < 3; c++) tick(1'b0, 3'b000, 3'b010);
    tick(1'b0, 3'b010, 3'b010);
    total++;
    if (traffic2 !== 16'd3) begin
      bad++; $display("FAIL coincident_arr_dep got=%0d want=3", traffic2);
    end
    for (int c = 0; c < 3; c++) tick(1'b0, 3'b000, 3'b010);
    total++;
    if (traffic2 !== 16'd3) begin
      bad++; $display("FAIL coincident_hold got=%0d want=3", traffic2);
    end
    tick(1'b0, 3'b000, 3'b010);
    total++;
    if (traffic2 !== 16'd2) begin
      bad++; $display("FAIL coincident_next_dep got=%0d want=2", traffic2);
    end
  endtask

  task automatic test_emerg();
    for (int p = 0; p < 10; p++) begin
      tick(1'b0, 3'b100, 3'b000);
      if (p < 9) tick(1'b0, 3'b000, 3'b000);
    end
    total++;
    if (traffic3 !== 16'd10 || emerg !== 1'b0) begin
      bad++; $display("FAIL emerg_at_on got=%0d/%0b want=10/0", traffic3, emerg);
    end
    tick(1'b0, 3'b000, 3'b000);
    total++;
    if (emerg !== 1'b1) begin
      bad++; $display("FAIL emerg_rise got=%0b want=1", emerg);
    end
    for (int c = 0; c < 4; c++) tick(1'b0, 3'b000, 3'b100);
    total++;
    if (traffic3 !== 16'd9 || emerg !== 1'b1) begin
      bad++; $display("FAIL emerg_hold_9 got=%0d/%0b want=9/1", traffic3, emerg);
    end
    for (int c = 0; c < 8; c++) tick(1'b0, 3'b000, 3'b100);
    total++;
    if (traffic3 !== 16'd7 || emerg !== 1'b1) begin
      bad++; $display("FAIL emerg_hold_7 got=%0d/%0b want=7/1", traffic3, emerg);
    end
    tick(1'b0, 3'b000, 3'b000);
    total++;
    if (emerg !== 1'b0) begin
      bad++; $display("FAIL emerg_fall got=%0b want=0", emerg);
    end
  endtask

  task automatic test_midreset();
    tick(1'b1, 3'b000, 3'b000);
    total++;
    if ({traffic1, traffic2, traffic3} !== 48'd0 || emerg !== 1'b0) begin
      bad++; $display("FAIL midreset got=%0d/%0d/%0d/%0b want=0/0/0/0",
                      traffic1, traffic2, traffic3, emerg);
    end
    tick(1'b0, 3'b000, 3'b000);
  endtask

  task automatic test_saturation();
    @(negedge clk); rst_b = 1'b1; sensor_b = 3'b000; green_b = 3'b000;
    @(negedge clk); rst_b = 1'b0;
    for (int p = 0; p < 18; p++) begin
      @(negedge clk); sensor_b = 3'b001;
      @(negedge clk); sensor_b = 3'b000;
      if (p == 14) begin
        total++;
        if (traffic1_b !== 4'd15 || sat_b !== 3'b000) begin
          bad++; $display("FAIL sat_at_max got=%0d/%b want=15/000", traffic1_b, sat_b);
        end
      end
    end
    total++;
    if (traffic1_b !== 4'd15 || sat_b !== 3'b001) begin
      bad++; $display("FAIL sat_overflow got=%0d/%b want=15/001", traffic1_b, sat_b);
    end
    green_b = 3'b001;
    repeat (4) @(negedge clk);
    green_b = 3'b000;
    total++;
    if (traffic1_b !== 4'd14 || sat_b !== 3'b001) begin
      bad++; $display("FAIL sat_sticky got=%0d/%b want=14/001", traffic1_b, sat_b);
    end
    repeat (3) @(negedge clk);
    total++;
    if (sat_b !== 3'b001) begin
      bad++; $display("FAIL sat_hold got=%b want=001", sat_b);
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    total++;
    if (sat_b !== 3'b000 || traffic1_b !== 4'd0) begin
      bad++; $display("FAIL sat_clear got=%0d/%b want=0/000", traffic1_b, sat_b);
    end
  endtask

  initial begin
    rst = 1'b1; sensor = 3'b111; green = 3'b000;
    rst_b = 1'b1; sensor_b = 3'b000; green_b = 3'b000;
    test_reset();
    test_arrivals();
    test_departure();
    test_back_to_back();
    test_emerg();
    test_midreset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
